// File: rtl/adc_sample_averager_pkg.sv
// Shared constants and FSM state encoding for the XADC sample averager.
package adc_pkg;
  localparam int ADC_BITS   = 12;
  localparam int DRP_ADDR_W = 7;
  localparam int CHAN_W     = 5;
  localparam int DRP_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_RDY = 2'd1,
    ACCUM    = 2'd2
  } state_t;
endpackage

// File: rtl/adc_sample_averager_if.sv
// XADC end-of-conversion and DRP read-port signals seen by the averager.
interface adc_sample_averager_if;
  import adc_pkg::*;

  logic                  eoc_in;
  logic [CHAN_W-1:0]     channel_in;
  logic [DRP_DATA_W-1:0] do_in;
  logic                  drdy_in;
  logic                  den_out;
  logic [DRP_ADDR_W-1:0] daddr_out;
  logic                  dwe_out;

  modport master (
    input  eoc_in, channel_in, do_in, drdy_in,
    output den_out, daddr_out, dwe_out
  );

  modport slave (
    output eoc_in, channel_in, do_in, drdy_in,
    input  den_out, daddr_out, dwe_out
  );
endinterface

// File: rtl/adc_drp_reader.sv
// DRP read handshake: eoc launches one read, drdy delivers the sample or the
// wait times out; eoc arriving while a read is in flight is flagged as overrun.
module adc_drp_reader
  import adc_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset,
  adc_sample_averager_if.master drp,
  output logic [ADC_BITS-1:0] sample,
  output logic                sample_vld,
  output logic                err_timeout,
  output logic                err_overrun
);
  localparam int TMR_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  state_t           state, state_nxt;
  logic [TMR_W-1:0] timer;
  logic             start, accept, expire;
  logic [ADC_BITS-1:0] sample_p1;

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    accept    = 1'b0;
    expire    = 1'b0;
    unique case (state)
      IDLE: begin
        if (drp.eoc_in) begin
          start     = 1'b1;
          state_nxt = WAIT_RDY;
        end
      end
      WAIT_RDY: begin
        // drdy wins over a timeout expiring in the same cycle
        if (drp.drdy_in) begin
          accept    = 1'b1;
          state_nxt = ACCUM;
        end else if (timer == TMR_W'(TIMEOUT)) begin
          expire    = 1'b1;
          state_nxt = IDLE;
        end
      end
      ACCUM:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      timer         <= '0;
      drp.den_out   <= 1'b0;
      drp.daddr_out <= '0;
      err_timeout   <= 1'b0;
      err_overrun   <= 1'b0;
    end else begin
      state       <= state_nxt;
      drp.den_out <= start;
      if (start) drp.daddr_out <= {2'b00, drp.channel_in};
      timer       <= (state == WAIT_RDY) ? timer + 1'b1 : '0;
      if (expire) err_timeout <= 1'b1;
      if (drp.eoc_in && state != IDLE) err_overrun <= 1'b1;
    end
  end

  // Sample register carries data only; its validity is tracked by the FSM.
  always_ff @(posedge clk) begin
    if (accept) sample_p1 <= drp.do_in[15:4];
  end

  assign drp.dwe_out = 1'b0;
  assign sample      = sample_p1;
  assign sample_vld  = (state == ACCUM);
endmodule

// File: rtl/adc_sample_averager.sv
// Averages windows of 2^LOG2_N XADC samples, reporting mean, min and max of
// each completed window with a one-cycle avg_valid strobe.
module adc_sample_averager
  import adc_pkg::*;
#(
  parameter int LOG2_N  = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset,
  adc_sample_averager_if.master drp,
  output logic [ADC_BITS-1:0] avg_out,
  output logic [ADC_BITS-1:0] min_out,
  output logic [ADC_BITS-1:0] max_out,
  output logic                avg_valid,
  output logic                err_timeout,
  output logic                err_overrun
);
  localparam int ACC_W = ADC_BITS + LOG2_N;

  logic [ADC_BITS-1:0] sample;
  logic                sample_vld;
  logic [ACC_W-1:0]    acc, acc_sum;
  logic [LOG2_N-1:0]   cnt;
  logic [ADC_BITS-1:0] run_min, run_max, win_min, win_max;
  logic                last;

  function automatic logic [ADC_BITS-1:0] avg_trunc(input logic [ACC_W-1:0] sum);
    return sum[ACC_W-1:LOG2_N];
  endfunction

  adc_drp_reader #(
    .TIMEOUT(TIMEOUT)
  ) u_reader (
    .clk        (clk),
    .reset      (reset),
    .drp        (drp),
    .sample     (sample),
    .sample_vld (sample_vld),
    .err_timeout(err_timeout),
    .err_overrun(err_overrun)
  );

  always_comb begin
    acc_sum = acc + ACC_W'(sample);
    win_min = (sample < run_min) ? sample : run_min;
    win_max = (sample > run_max) ? sample : run_max;
    last    = &cnt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc       <= '0;
      cnt       <= '0;
      run_min   <= '1;
      run_max   <= '0;
      avg_out   <= '0;
      min_out   <= '0;
      max_out   <= '0;
      avg_valid <= 1'b0;
    end else begin
      avg_valid <= 1'b0;
      if (sample_vld) begin
        cnt <= cnt + 1'b1;
        // Window closes on the sample that wraps cnt back to zero
        if (last) begin
          avg_out   <= avg_trunc(acc_sum);
          min_out   <= win_min;
          max_out   <= win_max;
          avg_valid <= 1'b1;
          acc       <= '0;
          run_min   <= '1;
          run_max   <= '0;
        end else begin
          acc     <= acc_sum;
          run_min <= win_min;
          run_max <= win_max;
        end
      end
    end
  end
endmodule

// File: tb/tb_adc_sample_averager.sv
// Drives two averagers (windows of 4 and 16) with one shared XADC/DRP stream
// and compares both against a queue-based window model.
module tb_adc_sample_averager;
  logic clk = 1'b0;
  logic reset;
  logic eoc, drdy;
  logic [4:0]  chan;
  logic [15:0] dat;

  always #5 clk = ~clk;

  adc_sample_averager_if if2 ();
  adc_sample_averager_if if4 ();

  assign if2.eoc_in = eoc;  assign if2.channel_in = chan;
  assign if2.do_in  = dat;  assign if2.drdy_in    = drdy;
  assign if4.eoc_in = eoc;  assign if4.channel_in = chan;
  assign if4.do_in  = dat;  assign if4.drdy_in    = drdy;

  logic [11:0] avg2, min2, max2, avg4, min4, max4;
  logic vld2, vld4, eto2, eto4, eov2, eov4;

  adc_sample_averager #(.LOG2_N(2), .TIMEOUT(15)) dut2 (
    .clk(clk), .reset(reset), .drp(if2),
    .avg_out(avg2), .min_out(min2), .max_out(max2), .avg_valid(vld2),
    .err_timeout(eto2), .err_overrun(eov2)
  );

  adc_sample_averager #(.LOG2_N(4), .TIMEOUT(15)) dut4 (
    .clk(clk), .reset(reset), .drp(if4),
    .avg_out(avg4), .min_out(min4), .max_out(max4), .avg_valid(vld4),
    .err_timeout(eto4), .err_overrun(eov4)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [11:0] q2[$], q4[$];
  logic [11:0] e_avg2, e_min2, e_max2, e_avg4, e_min4, e_max4;
  bit want2, want4, e_to, e_ov;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic summarize(input logic [11:0] q[$], output logic [11:0] a,
                           output logic [11:0] mn, output logic [11:0] mx);
    int sum = 0;
    mn = 12'hFFF;
    mx = 12'h000;
    foreach (q[i]) begin
      sum += int'(q[i]);
      if (q[i] < mn) mn = q[i];
      if (q[i] > mx) mx = q[i];
    end
    a = 12'(sum / q.size());
  endtask

  task automatic model_reset();
    q2.delete(); q4.delete();
    e_avg2 = 0; e_min2 = 0; e_max2 = 0;
    e_avg4 = 0; e_min4 = 0; e_max4 = 0;
    want2 = 0; want4 = 0; e_to = 0; e_ov = 0;
  endtask

  task automatic model_accept(input logic [11:0] s);
    q2.push_back(s); q4.push_back(s);
    want2 = 0; want4 = 0;
    if (q2.size() == 4) begin
      summarize(q2, e_avg2, e_min2, e_max2); want2 = 1; q2.delete();
    end
    if (q4.size() == 16) begin
      summarize(q4, e_avg4, e_min4, e_max4); want4 = 1; q4.delete();
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".avg2"}, avg2, e_avg2); chk({tag, ".min2"}, min2, e_min2);
    chk({tag, ".max2"}, max2, e_max2); chk({tag, ".avg4"}, avg4, e_avg4);
    chk({tag, ".min4"}, min4, e_min4); chk({tag, ".max4"}, max4, e_max4);
    chk({tag, ".eto2"}, eto2, e_to);   chk({tag, ".eto4"}, eto4, e_to);
    chk({tag, ".eov2"}, eov2, e_ov);   chk({tag, ".eov4"}, eov4, e_ov);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    model_reset();
  endtask

  // One eoc -> den -> (k cycles) -> drdy transaction; k > 15 means no drdy.
  task automatic txn(input logic [4:0] c, input logic [15:0] d, input int k, input bit probe);
    eoc = 1'b1; chan = c;
    tick();
    eoc = 1'b0;
    chk("den_pulse", if2.den_out, 1'b1);
    chk("den_pulse4", if4.den_out, 1'b1);
    chk("daddr", if2.daddr_out, {2'b00, c});
    chk("dwe", if2.dwe_out, 1'b0);
    if (k > 15) begin
      repeat (15) begin
        tick();
        chk("den_idle", if2.den_out, 1'b0);
      end
      chk("eto_pre", eto2, e_to);
      tick();
      e_to = 1;
      chk("den_after_to", if2.den_out, 1'b0);
      check_outputs("timeout");
      return;
    end
    for (int i = 0; i < k; i++) begin
      if (probe && i == 0) eoc = 1'b1;
      tick();
      eoc = 1'b0;
      if (probe && i == 0) e_ov = 1;
      chk("den_wait", if2.den_out, 1'b0);
      chk("den_wait4", if4.den_out, 1'b0);
    end
    drdy = 1'b1; dat = d;
    tick();
    drdy = 1'b0; dat = 16'($urandom);
    chk("den_accum", if2.den_out, 1'b0);
    chk("vld_early2", vld2, 1'b0);
    chk("vld_early4", vld4, 1'b0);
    model_accept(d[15:4]);
    tick();
    chk("avg_valid2", vld2, want2);
    chk("avg_valid4", vld4, want4);
    check_outputs("txn");
  endtask

  initial begin
    eoc = 0; drdy = 0; chan = 0; dat = 0; reset = 1'b1;
    model_reset();
    tick(); tick(); tick();
    chk("rst_den", if2.den_out, 1'b0);
    chk("rst_daddr", if2.daddr_out, 7'h00);
    chk("rst_vld", vld2, 1'b0);
    check_outputs("reset");
    reset = 1'b0;
    tick();
    check_outputs("post_reset");

    // Four-sample window with mixed drdy latencies, incl. drdy on the timeout cycle
    txn(5'h15, 16'h1000, 0, 0);
    txn(5'h03, 16'h2000, 3, 0);
    txn(5'h07, 16'h3000, 15, 0);
    chk("boundary_no_to", eto2, 1'b0);
    txn(5'h01, 16'h4000, 1, 0);
    chk("win4_avg", avg2, 12'h280);

    // Missing drdy, then normal traffic resumes without counting the lost sample
    txn(5'h02, 16'hABCD, 16, 0);
    txn(5'h04, 16'h1230, 2, 0);
    // eoc while waiting for drdy
    txn(5'h08, 16'h5670, 3, 1);
    repeat (2) tick();
    check_outputs("idle_hold");

    // Full-scale window must not overflow the accumulator
    do_reset();
    for (int i = 0; i < 16; i++) txn(5'(i), 16'hFFF0, i % 4, 0);
    chk("fullscale4", avg4, 12'hFFF);

    // Mid-window reset, reset during a pending read, then a small-value window
    for (int i = 0; i < 5; i++) txn(5'h0A, 16'h0010, 1, 0);
    do_reset();
    check_outputs("mid_reset");
    eoc = 1'b1; chan = 5'h06;
    tick();
    eoc = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    drdy = 1'b1; dat = 16'h7770;
    tick();
    drdy = 1'b0;
    tick(); tick();
    chk("stale_drdy2", vld2, 1'b0);
    chk("stale_drdy4", vld4, 1'b0);
    check_outputs("stale_drdy");
    for (int i = 0; i < 16; i++) txn(5'h0B, 16'h0010, 0, 0);
    chk("small4", avg4, 12'h001);

    // Randomized traffic
    for (int n = 0; n < 48; n++) begin
      int k;
      bit p;
      k = int'($urandom_range(0, 18));
      p = (k >= 2) && ($urandom_range(0, 7) == 0);
      txn(5'($urandom), 16'($urandom), k, p);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
